// File: rtl/bus_copy_pkg.sv
// Shared types and widths for the bus copy master: FSM state encoding and bus widths.
// The checksum (BUS_COPY_SUM_EN) is configured in bus_copy_master.
package bus_copy_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } state_e;
endpackage

// File: rtl/bus_copy_agen.sv
// Address generator: latches source/destination bases and length, keeps the word index,
// and produces modulo-256 read/write addresses plus a last-word flag.
module bus_copy_agen
  import bus_copy_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              inc,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last
);
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    idx_d = idx_q;
    if (load) begin
      src_d = src_in;
      dst_d = dst_in;
      len_d = len_in;
      idx_d = '0;
    end else if (inc) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end

  // 8-bit sums wrap naturally past 8'hFF.
  assign rd_addr = src_q + ADDR_W'(idx_q);
  assign wr_addr = dst_q + ADDR_W'(idx_q);
  assign last    = ({1'b0, idx_q} + (LEN_W + 1)'(1)) == {1'b0, len_q};
endmodule

// File: rtl/bus_copy_master.sv
// Bus copy master: copies length words src->dst over a granted bus, one word per RD/CAP/WR.
// Define BUS_COPY_SUM_EN to enable the running checksum on sum; otherwise sum is tied to zero.
module bus_copy_master
  import bus_copy_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              M_req,
  input  logic              M_grant,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_dout,
  input  logic [DATA_W-1:0] M_din,
  output logic [DATA_W-1:0] sum
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              zdone_q, zdone_d;
  logic              load, inc, last;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  bus_copy_agen u_agen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .src_in  (src_addr),
    .dst_in  (dst_addr),
    .len_in  (length),
    .inc     (inc),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    zdone_d = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    M_req   = 1'b0;
    M_wr    = 1'b0;
    M_addr  = '0;
    M_dout  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          // A zero-length request completes without ever touching the bus or raising busy.
          if (length == '0) zdone_d = 1'b1;
          else              state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        M_req = 1'b1;
        if (M_grant) state_d = ST_RD;
      end
      ST_RD: begin
        M_req   = 1'b1;
        M_addr  = rd_addr;
        state_d = M_grant ? ST_CAP : ST_REQ;
      end
      ST_CAP: begin
        M_req = 1'b1;
        if (M_grant) begin
          buf_d   = M_din;
          state_d = ST_WR;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WR: begin
        M_req  = 1'b1;
        M_addr = wr_addr;
        M_dout = buf_q;
        // Losing grant here drops the write; the word is re-read after regrant.
        if (M_grant) begin
          M_wr    = 1'b1;
          inc     = 1'b1;
          state_d = last ? ST_DONE : ST_RD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      zdone_q <= zdone_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE) | zdone_q;

`ifdef BUS_COPY_SUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  // The captured word is accumulated when its write commits, so abandoned words never count.
  always_comb begin
    sum_d = sum_q;
    if (load)                                 sum_d = '0;
    else if ((state_q == ST_WR) && M_grant)   sum_d = sum_q + buf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum = sum_q;
`else
  assign sum = '0;
`endif
endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: slave memory model plus an array-level copy reference.
module tb_bus_copy_master;
  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  src_addr, dst_addr;
  logic [4:0]  length;
  logic        busy, done, M_req, M_grant, M_wr;
  logic [7:0]  M_addr;
  logic [31:0] M_dout, M_din, sum;

  bus_copy_master dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .M_req(M_req), .M_grant(M_grant),
    .M_wr(M_wr), .M_addr(M_addr), .M_dout(M_dout), .M_din(M_din), .sum(sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: registered read, write on granted write cycle, and a write log.
  logic [31:0] mem [256];
  logic [31:0] rdata;
  logic [7:0]  wr_log [64];
  int          wr_cnt;
  logic        init_req, poke_en, clr_log;
  logic [31:0] seed, poke_dat;
  logic [7:0]  poke_addr;

  function automatic logic [31:0] init_word(input logic [31:0] s, input int a);
    return s ^ (32'(a) * 32'h9E3779B1) ^ 32'(a);
  endfunction

  assign M_din = rdata;

  always @(posedge clk) begin
    rdata <= mem[M_addr];
    if (init_req) for (int i = 0; i < 256; i++) mem[i] <= init_word(seed, i);
    if (poke_en) mem[poke_addr] <= poke_dat;
    if (clr_log) wr_cnt <= 0;
    else if (M_req && M_grant && M_wr) begin
      mem[M_addr] <= M_dout;
      wr_log[wr_cnt[5:0]] <= M_addr;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int          checks, errors;
  logic [31:0] model [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] sum_exp(input logic [31:0] s);
`ifdef BUS_COPY_SUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  task automatic init_mem(input logic [31:0] s);
    seed = s; init_req = 1'b1;
    step();
    init_req = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = init_word(s, i);
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    poke_addr = a; poke_dat = d; poke_en = 1'b1;
    step();
    poke_en = 1'b0;
    model[a] = d;
  endtask

  // Reference: ascending word-by-word copy, so overlapping ranges see earlier copied words.
  task automatic apply_model(input logic [7:0] s, input logic [7:0] d, input int n,
                             output logic [31:0] total);
    logic [31:0] w;
    total = 32'h0;
    for (int i = 0; i < n; i++) begin
      w = model[s + 8'(i)];
      model[d + 8'(i)] = w;
      total = total + w;
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) bad++;
    check(tag, 32'(bad), 32'h0);
  endtask

  task automatic check_wlog(input string tag, input logic [7:0] d, input int n);
    check({tag, "_wcnt"}, 32'(wr_cnt), 32'(n));
    for (int i = 0; i < n && i < 64; i++)
      check({tag, "_waddr"}, {24'h0, wr_log[i]}, {24'h0, d + 8'(i)});
  endtask

  task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [4:0] n);
    step();
    src_addr = s; dst_addr = d; length = n; start = 1'b1; clr_log = 1'b1;
    step();
    start = 1'b0; clr_log = 1'b0;
  endtask

  task automatic run_copy(input int budget, input bit rand_gnt, output int req_cyc, output int dcnt);
    req_cyc = 0; dcnt = 0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin dcnt++; break; end
      if (M_req) req_cyc++;
      if (rand_gnt) M_grant = ($urandom_range(0, 3) != 0);
      step();
    end
    M_grant = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          req_cyc, dcnt, hold, phase, wr_at_regrant;
    bit          hit, seen;
    logic [31:0] s_exp;
    logic [7:0]  rs, rd;
    int          rn;

    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    M_grant = 1'b1; init_req = 1'b0; poke_en = 1'b0; clr_log = 1'b0;
    seed = '0; poke_dat = '0; poke_addr = '0;

    step(); step();
    check("reset_outs", 32'(|{M_req, M_wr, M_addr, M_dout, busy, done, sum}), 32'h0);
    reset = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'h0);
    init_mem($urandom);

    // Basic copy, grant held: one REQ cycle plus three cycles per word.
    start_copy(8'h00, 8'h80, 5'd4);
    check("copy_busy", 32'(busy), 32'h1);
    run_copy(200, 1'b0, req_cyc, dcnt);
    check("copy_done", 32'(dcnt), 32'h1);
    check("copy_cycles", 32'(req_cyc - 1), 32'(3 * 4));
    check("copy_req_in_done", 32'(M_req), 32'h0);
    step();
    check("copy_done_once", 32'(done), 32'h0);
    check("copy_idle", 32'(busy), 32'h0);
    apply_model(8'h00, 8'h80, 4, s_exp);
    check_wlog("copy", 8'h80, 4);
    check_mem("copy_mem");
    check("copy_sum", sum, sum_exp(s_exp));

    // Zero length.
    start_copy(8'h05, 8'h06, 5'd0);
    check("zero_done", 32'(done), 32'h1);
    check("zero_busy", 32'(busy), 32'h0);
    seen = M_req;
    for (int c = 0; c < 5; c++) begin step(); seen |= M_req; end
    check("zero_noreq", 32'(seen), 32'h0);
    check("zero_wcnt", 32'(wr_cnt), 32'h0);

    // Address wrap.
    start_copy(8'hFE, 8'h10, 5'd3);
    run_copy(200, 1'b0, req_cyc, dcnt);
    check("wrap_done", 32'(dcnt), 32'h1);
    apply_model(8'hFE, 8'h10, 3, s_exp);
    check_wlog("wrap", 8'h10, 3);
    check_mem("wrap_mem");

    // Grant lost during WR of word 1 for three cycles.
    start_copy(8'h20, 8'hA0, 5'd4);
    phase = 0; hold = 0; wr_at_regrant = -1; dcnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (done) begin dcnt++; break; end
      if (phase == 0 && M_wr && M_addr == 8'hA1) begin
        M_grant = 1'b0; phase = 1; hold = 3;
      end else if (phase == 1) begin
        hold--;
        if (hold == 0) begin wr_at_regrant = wr_cnt; M_grant = 1'b1; phase = 2; end
      end
      step();
    end
    M_grant = 1'b1;
    check("gl_phase", 32'(phase), 32'h2);
    check("gl_nowrite", 32'(wr_at_regrant), 32'h1);
    check("gl_done", 32'(dcnt), 32'h1);
    apply_model(8'h20, 8'hA0, 4, s_exp);
    check_wlog("gl", 8'hA0, 4);
    check_mem("gl_mem");
    check("gl_sum", sum, sum_exp(s_exp));

    // Start while busy is ignored.
    start_copy(8'h70, 8'hC0, 5'd3);
    step();
    start = 1'b1; src_addr = 8'h00; dst_addr = 8'h00; length = 5'd7;
    step();
    start = 1'b0;
    run_copy(200, 1'b0, req_cyc, dcnt);
    check("ign_done", 32'(dcnt), 32'h1);
    apply_model(8'h70, 8'hC0, 3, s_exp);
    check_wlog("ign", 8'hC0, 3);
    check_mem("ign_mem");

    // Reset in CAP of word 2 of 5.
    start_copy(8'h30, 8'h60, 5'd5);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (M_req && !M_wr && M_addr == 8'h32) hit = 1'b1;
      step();
    end
    check("rst_hit", 32'(hit), 32'h1);
    reset = 1'b1;
    #1;
    check("rst_outs", 32'(|{M_req, M_wr, M_addr, M_dout, busy, done, sum}), 32'h0);
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin step(); seen |= (M_req | busy | done); end
    check("rst_noresume", 32'(seen), 32'h0);
    apply_model(8'h30, 8'h60, 2, s_exp);
    check_wlog("rst", 8'h60, 2);
    check_mem("rst_mem");
    start_copy(8'h30, 8'h60, 5'd5);
    run_copy(300, 1'b0, req_cyc, dcnt);
    check("fresh_done", 32'(dcnt), 32'h1);
    apply_model(8'h30, 8'h60, 5, s_exp);
    check_wlog("fresh", 8'h60, 5);
    check_mem("fresh_mem");
    check("fresh_sum", sum, sum_exp(s_exp));

    // Checksum wraps modulo 2^32.
    poke(8'h50, 32'hFFFFFFFF);
    poke(8'h51, 32'h00000002);
    start_copy(8'h50, 8'h90, 5'd2);
    run_copy(200, 1'b0, req_cyc, dcnt);
    apply_model(8'h50, 8'h90, 2, s_exp);
    check("sum_model", s_exp, 32'h00000001);
    check("sum_chk", sum, sum_exp(32'h00000001));
    check_mem("sum_mem");

    // Random copies (overlap allowed) with random grant dropouts.
    for (int t = 0; t < 4; t++) begin
      rs = 8'($urandom); rd = 8'($urandom); rn = $urandom_range(1, 31);
      start_copy(rs, rd, 5'(rn));
      run_copy(3000, 1'b1, req_cyc, dcnt);
      check("rnd_done", 32'(dcnt), 32'h1);
      apply_model(rs, rd, rn, s_exp);
      check_wlog("rnd", rd, rn);
      check_mem("rnd_mem");
      check("rnd_sum", sum, sum_exp(s_exp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_copy_master.md
BUS_COPY_MASTER -- requirements
Module: bus_copy_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock) first, then reset (input, 1, asynchronous active-high reset).
REQ-002 The block SHALL have these control ports:
- start  input  1  one-cycle copy request
- src_addr  input  8  first source word address
- dst_addr  input  8  first destination word address
- length  input  5  words to copy, 0..31
- busy  output  1  high while a copy is in progress
- done  output  1  one-cycle completion pulse
REQ-003 The block SHALL have these bus master ports:
- M_req  output  1  bus request
- M_grant  input  1  arbiter grant
- M_wr  output  1  1 = write, 0 = read
- M_addr  output  8  slave address
- M_dout  output  32  write data
- M_din  input  32  read data
REQ-004 The block SHALL have sum (output, 32), the running checksum of copied words.

Function
REQ-005 On start in IDLE, the block SHALL latch src_addr, dst_addr and length, and SHALL clear the word index and sum.
REQ-006 The block SHALL ignore start while busy=1.
REQ-007 On start with length=0, the block SHALL pulse done on the next cycle, SHALL NOT assert M_req, and SHALL leave busy low.
REQ-008 The FSM SHALL have exactly these states:
- IDLE: on start with length>0, go to REQ.
- REQ: M_req=1; on M_grant, go to RD.
- RD: M_addr=src+idx, M_wr=0; next cycle go to CAP.
- CAP: register M_din into the data buffer; go to WR.
- WR: M_addr=dst+idx, M_wr=1, M_dout=buffer; then increment idx. If idx+1 equals length, go to DONE; otherwise go to RD.
- DONE: done=1 for one cycle; go to IDLE.
REQ-009 Read data SHALL be sampled exactly one cycle after the read address is driven (registered slave select path).
REQ-010 M_req SHALL stay high from REQ through WR of the final word, and SHALL be low in DONE and IDLE.
REQ-011 If M_grant is low in RD, CAP or WR, the block SHALL abandon the current word (no write issued), return to REQ with idx unchanged, and retry that word after the grant returns.
REQ-012 Address arithmetic SHALL be 8-bit modulo 256: src 8'hFF + 1 wraps to 8'h00, and likewise for dst.
REQ-013 In states other than RD, CAP and WR, M_wr SHALL be 0, M_addr SHALL be 8'h00 and M_dout SHALL be 32'h0.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Overlapping source and destination ranges SHALL be copied in ascending index order, with no hazard handling.

Reset
REQ-016 Asserting reset at any time, including mid-copy, SHALL immediately force IDLE with all outputs 0: M_req, M_wr, M_addr, M_dout, busy, done and sum.
REQ-017 After reset deasserts, the block SHALL require a fresh start; no copy SHALL resume.

Configuration
REQ-018 With BUS_COPY_SUM_EN defined, sum SHALL add each captured word modulo 2^32 in CAP, counting only words that are subsequently written.
REQ-019 With BUS_COPY_SUM_EN undefined, sum SHALL be constant 32'h0 and no adder SHALL be synthesized.

Structure
REQ-020 A shared package bus_copy_pkg SHALL hold the FSM state encoding, ADDR_W=8, DATA_W=32 and LEN_W=5.
REQ-021 Address generation (latched bases, idx counter, wrap adders) SHALL be a sub-module bus_copy_agen; the FSM and data buffer SHALL remain in the top.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Copy: src=8'h00, dst=8'h80, length=4, grant held high -> slave words 0..3 appear at 8'h80..8'h83; done pulses once; total 3*4 cycles from first grant.
- Zero length: length=0 -> done pulses on the next cycle; M_req never rises.
- Wrap: src=8'hFE, dst=8'h10, length=3 -> reads 8'hFE, 8'hFF, 8'h00; writes 8'h10..8'h12.
- Grant loss: M_grant dropped during WR of word 1 for 3 cycles -> no write to dst+1 in that pass; word 1 reread and written after regrant; final memory correct.
- Reset mid-copy: reset asserted in CAP of word 2 of 5 -> all outputs 0 same cycle; only dst+0 and dst+1 written; a start after reset performs a fresh copy.
- Checksum: BUS_COPY_SUM_EN defined, words 32'hFFFFFFFF and 32'h00000002 -> sum=32'h00000001; with the macro undefined -> sum=32'h0.
